// File: rtl/voice_allocator.sv
// Note scheduler for three note_player voices: accepts one note per handshake,
// loads the lowest free voice (or steals the oldest), and tracks occupancy.
module voice_allocator #(
    parameter bit STEAL_EN = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_note,
    input  logic [5:0]       req_duration,
    input  logic [1:0]       req_stereo,
    input  logic [2:0]       voice_done,
    output logic [2:0]       voice_load,
    output logic [17:0]      voice_note,
    output logic [17:0]      voice_duration,
    output logic [5:0]       voice_stereo,
    output logic [2:0]       busy,
    output logic             steal,
    output logic [CNT_W-1:0] steal_count
);

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [1:0] rank      [3];
    logic [1:0] rank_base [3];
    logic [1:0] rank_next [3];
    logic [1:0] old_rank;

    logic [5:0] note_r     [3];
    logic [5:0] duration_r [3];
    logic [1:0] stereo_r   [3];

    logic [2:0] done_eff;
    logic [2:0] free_set;
    logic [2:0] target;
    logic [2:0] busy_next;
    logic       all_busy;
    logic       accept;
    logic       do_steal;

    // A done pulse on a voice that is being loaded belongs to its previous note.
    assign done_eff = voice_done & ~voice_load;
    assign free_set = ~busy | done_eff;
    assign all_busy = (free_set == 3'b000);
    assign accept   = (state == IDLE) && req_valid && req_ready;
    assign do_steal = accept && all_busy;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !(!STEAL_EN && all_busy);
                if (req_valid && req_ready) begin
                    state_next = LOAD;
                end
            end
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        target = 3'b000;
        if (free_set[0]) begin
            target = 3'b001;
        end else if (free_set[1]) begin
            target = 3'b010;
        end else if (free_set[2]) begin
            target = 3'b100;
        end else if (STEAL_EN) begin
            for (int i = 0; i < 3; i++) begin
                if (rank[i] == 2'd2) begin
                    target[i] = 1'b1;
                end
            end
        end
    end

    // Ranks: 0 = most recently loaded, 2 = oldest. Flush restores the reset order
    // before an accept in the same cycle re-ranks on top of it.
    always_comb begin
        old_rank = 2'd0;
        for (int i = 0; i < 3; i++) begin
            rank_base[i] = flush ? 2'(i) : rank[i];
            if (target[i]) begin
                old_rank = rank_base[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            rank_next[i] = rank_base[i];
            if (accept) begin
                if (target[i]) begin
                    rank_next[i] = 2'd0;
                end else if (rank_base[i] < old_rank) begin
                    rank_next[i] = rank_base[i] + 2'd1;
                end
            end
        end
    end

    always_comb begin
        busy_next = flush ? 3'b000 : (busy & ~done_eff);
        if (accept) begin
            busy_next = busy_next | target;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 3'b000;
            voice_load  <= 3'b000;
            steal       <= 1'b0;
            steal_count <= '0;
            for (int i = 0; i < 3; i++) begin
                rank[i] <= 2'(i);
            end
        end else begin
            state      <= state_next;
            busy       <= busy_next;
            voice_load <= accept ? target : 3'b000;
            steal      <= do_steal;
            if (do_steal && (steal_count != {CNT_W{1'b1}})) begin
                steal_count <= steal_count + CNT_W'(1);
            end
            for (int i = 0; i < 3; i++) begin
                rank[i] <= rank_next[i];
            end
        end
    end

    // NOTE: the voice registers are only three entries, so they take the reset like any other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                note_r[i]     <= 6'd0;
                duration_r[i] <= 6'd0;
                stereo_r[i]   <= 2'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (accept && target[i]) begin
                    note_r[i]     <= req_note;
                    duration_r[i] <= req_duration;
                    stereo_r[i]   <= req_stereo;
                end
            end
        end
    end

    assign voice_note     = {note_r[2], note_r[1], note_r[0]};
    assign voice_duration = {duration_r[2], duration_r[1], duration_r[0]};
    assign voice_stereo   = {stereo_r[2], stereo_r[1], stereo_r[0]};

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: one instance with stealing, one that stalls.
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [5:0]  req_note;
    logic [5:0]  req_duration;
    logic [1:0]  req_stereo;

    logic        valid_s, ready_s, steal_s;
    logic [2:0]  done_s, load_s, busy_s;
    logic [17:0] note_s, dur_s;
    logic [5:0]  st_s;
    logic [7:0]  cnt_s;

    logic        valid_h, ready_h, steal_h;
    logic [2:0]  done_h, load_h, busy_h;
    logic [17:0] note_h, dur_h;
    logic [5:0]  st_h;
    logic [7:0]  cnt_h;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    voice_allocator #(.STEAL_EN(1'b1), .CNT_W(8)) dut_s (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(valid_s), .req_ready(ready_s),
        .req_note(req_note), .req_duration(req_duration), .req_stereo(req_stereo),
        .voice_done(done_s), .voice_load(load_s),
        .voice_note(note_s), .voice_duration(dur_s), .voice_stereo(st_s),
        .busy(busy_s), .steal(steal_s), .steal_count(cnt_s)
    );

    voice_allocator #(.STEAL_EN(1'b0), .CNT_W(8)) dut_h (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(valid_h), .req_ready(ready_h),
        .req_note(req_note), .req_duration(req_duration), .req_stereo(req_stereo),
        .voice_done(done_h), .voice_load(load_h),
        .voice_note(note_h), .voice_duration(dur_h), .voice_stereo(st_h),
        .busy(busy_h), .steal(steal_h), .steal_count(cnt_h)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one note for one cycle; returns in the LOAD cycle that follows the accept edge.
    task automatic send(input bit hold, input logic [5:0] n);
        req_note     = n;
        req_duration = 6'd4;
        req_stereo   = 2'b01;
        if (hold) valid_h = 1'b1;
        else      valid_s = 1'b1;
        tick();
        valid_s = 1'b0;
        valid_h = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; valid_s = 1'b0; valid_h = 1'b0;
        done_s = 3'b000; done_h = 3'b000;
        req_note = 6'd0; req_duration = 6'd0; req_stereo = 2'b00;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (load_s !== 3'b000) begin errors++; $display("FAIL reset_load: got %b expected 000", load_s); end
        checks++; if (busy_s !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b expected 000", busy_s); end
        checks++; if (steal_s !== 1'b0) begin errors++; $display("FAIL reset_steal: got %b expected 0", steal_s); end
        checks++; if (cnt_s !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt_s); end
        checks++; if (note_s !== 18'd0) begin errors++; $display("FAIL reset_note: got %h expected 0", note_s); end
        checks++; if (ready_s !== 1'b1) begin errors++; $display("FAIL reset_ready_s: got %b expected 1", ready_s); end
        checks++; if (ready_h !== 1'b1) begin errors++; $display("FAIL reset_ready_h: got %b expected 1", ready_h); end
    endtask

    task automatic test_fill;
        send(1'b0, 6'd10);
        checks++; if (load_s !== 3'b001) begin errors++; $display("FAIL fill_load0: got %b expected 001", load_s); end
        checks++; if (ready_s !== 1'b0) begin errors++; $display("FAIL fill_ready_in_load: got %b expected 0", ready_s); end
        tick();
        checks++; if (load_s !== 3'b000) begin errors++; $display("FAIL fill_load_width: got %b expected 000", load_s); end
        checks++; if (ready_s !== 1'b1) begin errors++; $display("FAIL fill_ready_idle: got %b expected 1", ready_s); end
        send(1'b0, 6'd20);
        checks++; if (load_s !== 3'b010) begin errors++; $display("FAIL fill_load1: got %b expected 010", load_s); end
        tick();
        send(1'b0, 6'd30);
        checks++; if (load_s !== 3'b100) begin errors++; $display("FAIL fill_load2: got %b expected 100", load_s); end
        tick();
        checks++; if (busy_s !== 3'b111) begin errors++; $display("FAIL fill_busy: got %b expected 111", busy_s); end
        checks++; if (note_s !== {6'd30, 6'd20, 6'd10}) begin errors++; $display("FAIL fill_note: got %h expected %h", note_s, {6'd30, 6'd20, 6'd10}); end
        checks++; if (dur_s !== {6'd4, 6'd4, 6'd4}) begin errors++; $display("FAIL fill_duration: got %h expected %h", dur_s, {6'd4, 6'd4, 6'd4}); end
        checks++; if (st_s !== 6'b010101) begin errors++; $display("FAIL fill_stereo: got %b expected 010101", st_s); end
        checks++; if (ready_s !== 1'b1) begin errors++; $display("FAIL fill_ready_all_busy: got %b expected 1", ready_s); end
    endtask

    task automatic test_steal;
        send(1'b0, 6'd40);
        checks++; if (load_s !== 3'b001) begin errors++; $display("FAIL steal_load: got %b expected 001", load_s); end
        checks++; if (steal_s !== 1'b1) begin errors++; $display("FAIL steal_pulse: got %b expected 1", steal_s); end
        checks++; if (cnt_s !== 8'd1) begin errors++; $display("FAIL steal_count1: got %0d expected 1", cnt_s); end
        checks++; if (note_s[5:0] !== 6'd40) begin errors++; $display("FAIL steal_note: got %0d expected 40", note_s[5:0]); end
        tick();
        checks++; if (steal_s !== 1'b0) begin errors++; $display("FAIL steal_pulse_width: got %b expected 0", steal_s); end
        send(1'b0, 6'd50);
        checks++; if (load_s !== 3'b010) begin errors++; $display("FAIL steal_next_oldest: got %b expected 010", load_s); end
        checks++; if (cnt_s !== 8'd2) begin errors++; $display("FAIL steal_count2: got %0d expected 2", cnt_s); end
        checks++; if (note_s[11:6] !== 6'd50) begin errors++; $display("FAIL steal_note1: got %0d expected 50", note_s[11:6]); end
        tick();
    endtask

    task automatic test_flush;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (busy_s !== 3'b000) begin errors++; $display("FAIL flush_busy: got %b expected 000", busy_s); end
        checks++; if (cnt_s !== 8'd2) begin errors++; $display("FAIL flush_count: got %0d expected 2", cnt_s); end
        send(1'b0, 6'd60);
        checks++; if (load_s !== 3'b001 || steal_s !== 1'b0) begin errors++; $display("FAIL flush_first: got load %b steal %b expected 001 0", load_s, steal_s); end
        tick();
        send(1'b0, 6'd61);
        checks++; if (load_s !== 3'b010) begin errors++; $display("FAIL flush_second: got %b expected 010", load_s); end
        tick();
        send(1'b0, 6'd62);
        tick();
        send(1'b0, 6'd63);
        checks++; if (load_s !== 3'b001 || cnt_s !== 8'd3) begin errors++; $display("FAIL flush_rank_steal: got load %b count %0d expected 001 3", load_s, cnt_s); end
        tick();
        // flush on the accept edge: ranks are now v0=0 v1=2 v2=1, so voice1 is stolen
        flush = 1'b1;
        send(1'b0, 6'd7);
        flush = 1'b0;
        checks++; if (load_s !== 3'b010 || steal_s !== 1'b1) begin errors++; $display("FAIL flush_accept_load: got load %b steal %b expected 010 1", load_s, steal_s); end
        checks++; if (busy_s !== 3'b010) begin errors++; $display("FAIL flush_accept_busy: got %b expected 010", busy_s); end
        tick();
    endtask

    task automatic test_done_in_load;
        send(1'b0, 6'd12);
        checks++; if (load_s !== 3'b001) begin errors++; $display("FAIL done_load: got %b expected 001", load_s); end
        done_s = 3'b001;
        tick();
        done_s = 3'b000;
        checks++; if (busy_s !== 3'b011) begin errors++; $display("FAIL done_ignored_in_load: got %b expected 011", busy_s); end
        done_s = 3'b001;
        tick();
        done_s = 3'b000;
        checks++; if (busy_s !== 3'b010) begin errors++; $display("FAIL done_clears: got %b expected 010", busy_s); end
    endtask

    task automatic test_stall;
        send(1'b1, 6'd1); tick();
        send(1'b1, 6'd2); tick();
        send(1'b1, 6'd3); tick();
        checks++; if (busy_h !== 3'b111) begin errors++; $display("FAIL stall_busy: got %b expected 111", busy_h); end
        req_note = 6'd33;
        valid_h  = 1'b1;
        #1;
        checks++; if (ready_h !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", ready_h); end
        tick();
        checks++; if (load_h !== 3'b000 || ready_h !== 1'b0) begin errors++; $display("FAIL stall_hold: got load %b ready %b expected 000 0", load_h, ready_h); end
        done_h = 3'b010;
        #1;
        checks++; if (ready_h !== 1'b1) begin errors++; $display("FAIL stall_done_bypass: got %b expected 1", ready_h); end
        tick();
        done_h  = 3'b000;
        valid_h = 1'b0;
        checks++; if (load_h !== 3'b010) begin errors++; $display("FAIL stall_load: got %b expected 010", load_h); end
        checks++; if (busy_h !== 3'b111 || steal_h !== 1'b0) begin errors++; $display("FAIL stall_busy_after: got busy %b steal %b expected 111 0", busy_h, steal_h); end
        checks++; if (note_h[11:6] !== 6'd33) begin errors++; $display("FAIL stall_note: got %0d expected 33", note_h[11:6]); end
        tick();
    endtask

    task automatic test_reset_in_load;
        send(1'b0, 6'd20);
        checks++; if (load_s !== 3'b001) begin errors++; $display("FAIL rst_load_before: got %b expected 001", load_s); end
        reset = 1'b1;
        tick();
        checks++; if (load_s !== 3'b000 || busy_s !== 3'b000 || steal_s !== 1'b0) begin errors++; $display("FAIL rst_in_load: got load %b busy %b steal %b expected 000 000 0", load_s, busy_s, steal_s); end
        checks++; if (cnt_s !== 8'd0 || note_s !== 18'd0) begin errors++; $display("FAIL rst_regs: got count %0d note %h expected 0 0", cnt_s, note_s); end
        reset = 1'b0;
        tick();
        checks++; if (ready_s !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", ready_s); end
    endtask

    task automatic test_saturation;
        for (int k = 0; k < 303; k++) begin
            send(1'b0, 6'(k));
            if (k == 256) begin
                checks++; if (cnt_s !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", cnt_s); end
            end
            if (k == 257) begin
                checks++; if (cnt_s !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", cnt_s); end
            end
            tick();
        end
        checks++; if (cnt_s !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", cnt_s); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_steal();
        test_flush();
        test_done_in_load();
        test_stall();
        test_reset_in_load();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
